// File: rtl/rw_stage.sv
// Register-write stage: MA/RW pipeline latch feeding the register-file write
// port, the EX forwarding path and the retired-instruction counter.
module rw_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] input_RW_PC,
    input  logic [31:0] input_RW_ALU_Result,
    input  logic [31:0] input_RW_Ld_Result,
    input  logic [31:0] input_RW_IR,
    input  logic [21:0] input_RW_controlBus,
    input  logic        input_RW_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        rf_writeEnable,
    output logic [3:0]  rf_writeAddr,
    output logic [31:0] rf_writeData,
    output logic        fwd_valid,
    output logic [3:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic [31:0] output_RW_PC,
    output logic [31:0] output_RW_IR,
    output logic [31:0] retired_count
);

    logic [31:0] pc_r;
    logic [31:0] alu_r;
    logic [31:0] ld_r;
    logic [31:0] ir_r;
    logic [21:0] ctrl_r;
    logic        valid_r;
    logic [31:0] retired_count_r;

    logic        is_ld_s;
    logic        is_call_s;
    logic        is_wb_s;
    logic        wr_en_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] wb_data_s;
    logic [3:0]  wb_addr_s;
    logic        unused_ctrl_s;

    // MA/RW latch: flush injects a bubble and overrides stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= 32'd0;
            alu_r   <= 32'd0;
            ld_r    <= 32'd0;
            ir_r    <= 32'd0;
            ctrl_r  <= 22'd0;
            valid_r <= 1'b0;
        end else if (flush) begin
            pc_r    <= 32'd0;
            alu_r   <= 32'd0;
            ld_r    <= 32'd0;
            ir_r    <= 32'd0;
            ctrl_r  <= 22'd0;
            valid_r <= 1'b0;
        end else if (!stall) begin
            pc_r    <= input_RW_PC;
            alu_r   <= input_RW_ALU_Result;
            ld_r    <= input_RW_Ld_Result;
            ir_r    <= input_RW_IR;
            ctrl_r  <= input_RW_controlBus;
            valid_r <= input_RW_valid;
        end else begin
            pc_r    <= pc_r;
            alu_r   <= alu_r;
            ld_r    <= ld_r;
            ir_r    <= ir_r;
            ctrl_r  <= ctrl_r;
            valid_r <= valid_r;
        end
    end

    // A latched instruction retires at the edge that replaces it, so a stalled one counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count_r <= 32'd0;
        end else if (valid_r && (flush || !stall)) begin
            retired_count_r <= retired_count_r + 32'd1;
        end else begin
            retired_count_r <= retired_count_r;
        end
    end

    assign is_ld_s       = ctrl_r[1];
    assign is_call_s     = ctrl_r[2];
    assign is_wb_s       = ctrl_r[3];
    assign unused_ctrl_s = ^{ctrl_r[21:4], ctrl_r[0]};
    assign wr_en_s       = valid_r & is_wb_s;
    assign pc_plus4_s    = pc_r + 32'd4;

    // Write-back value selection: call link beats load result beats ALU result
    always_comb begin
        wb_data_s = alu_r;
        wb_addr_s = ir_r[25:22];
        if (is_call_s) begin
            wb_data_s = pc_plus4_s;
            wb_addr_s = 4'd15;
        end else if (is_ld_s) begin
            wb_data_s = ld_r;
            wb_addr_s = ir_r[25:22];
        end else begin
            wb_data_s = alu_r;
            wb_addr_s = ir_r[25:22];
        end
    end

    // Outputs depend on latch state only; an inactive port reads as all zeros
    always_comb begin
        rf_writeEnable = wr_en_s;
        rf_writeAddr   = 4'd0;
        rf_writeData   = 32'd0;
        if (wr_en_s) begin
            rf_writeAddr = wb_addr_s;
            rf_writeData = wb_data_s;
        end else begin
            rf_writeAddr = 4'd0;
            rf_writeData = 32'd0;
        end
    end

    assign fwd_valid     = rf_writeEnable;
    assign fwd_addr      = rf_writeAddr;
    assign fwd_data      = rf_writeData;
    assign output_RW_PC  = pc_r;
    assign output_RW_IR  = ir_r;
    assign retired_count = retired_count_r;

endmodule
